// File: rtl/icache_fill_if.sv
// Datapath fetch port and memory-controller word port of the instruction cache.
// slave: the cache side; master: the datapath plus memory controller side.
interface icache_fill_if;
    // Fetch: imemREN requests, ihit marks imemload valid that cycle.
    // Memory: iREN/iaddr held steady until a cycle with iwait low, when iload is taken.
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped 16 x 1-word instruction cache with single-word miss fill.
// Optional statistics counters enabled by defining ICACHE_STATS_EN.
module icache_fill (
    input  logic          CLK,
    input  logic          RST,
    icache_fill_if.slave  bus,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count,
    output logic          state_dbg_o
);
    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] valid_q;
    logic [31:0] data_q [16];
    logic [25:0] tag_q  [16];
    logic [31:0] miss_addr_q, miss_addr_d;

    logic [3:0]  req_idx;
    logic [3:0]  miss_idx;
    logic        lookup_hit;
    logic        start_miss;
    logic        fill;
    logic        hit_now;

    assign req_idx    = bus.imemaddr[5:2];
    assign miss_idx   = miss_addr_q[5:2];
    assign lookup_hit = bus.imemREN && valid_q[req_idx]
                        && (tag_q[req_idx] == bus.imemaddr[31:6]) && !bus.iflush;
    assign start_miss = (state_q == IDLE) && bus.imemREN && !lookup_hit && !bus.iflush;
    assign fill       = (state_q == MISS) && !bus.iwait;
    assign hit_now    = (state_q == IDLE) && lookup_hit;
    assign state_dbg_o = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        case (state_q)
            IDLE: if (start_miss) begin
                state_d     = MISS;
                miss_addr_d = bus.imemaddr & 32'hFFFF_FFFC;
            end
            MISS: if (!bus.iwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (state_q)
            IDLE: begin
                bus.ihit     = lookup_hit;
                bus.imemload = lookup_hit ? data_q[req_idx] : 32'h0;
            end
            MISS: begin
                bus.iREN  = 1'b1;
                bus.iaddr = miss_addr_q;
            end
            default: ;
        endcase
    end

    // A flush on the completing edge leaves the just-filled frame invalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)             valid_q <= '0;
        else if (bus.iflush) valid_q <= '0;
        else if (fill)       valid_q[miss_idx] <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[miss_idx] <= bus.iload;
            tag_q[miss_idx]  <= miss_addr_q[31:6];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_now)    hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif
endmodule
